// File: rtl/mux8lut_outreg_pkg.sv
// ============================================================================
// mux8lut_outreg_pkg : lane modes, lane count and config-bit layout for the
//                      MUX8LUT output register stage.       Rev 1.0
// ============================================================================
`default_nettype none

package mux8lut_outreg_pkg;

   localparam logic [1:0] MODE_BYPASS = 2'b00;
   localparam logic [1:0] MODE_REG1   = 2'b01;
   localparam logic [1:0] MODE_REG2   = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   localparam int NUM_LANES     = 4;
   localparam int CFG_MODE_W    = 2;
   localparam int CFG_SHIFT_BIT = NUM_LANES * CFG_MODE_W;

   function automatic int cfg_mode_lsb(input int lane);
      return lane * CFG_MODE_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mux8lut_outreg_lane.sv
// ============================================================================
// mux8lut_outreg_lane : one output lane (s1/s2 flops + output mode select).
// Optional macro: MUX8LUT_OUTREG_SHIFT_EN.                  Rev 1.0
// ============================================================================
`default_nettype none

module mux8lut_outreg_lane
   import mux8lut_outreg_pkg::*;
(
   input  logic       UserCLK,
   input  logic       SR,
   input  logic       EN,
   input  logic       D,
   input  logic [1:0] mode,
`ifdef MUX8LUT_OUTREG_SHIFT_EN
   input  logic       shift_sel,
   input  logic       shift_d,
`endif
   output logic       Q,
   output logic       s1
);

   logic s1_q;
   logic s1_d;
   logic s2_q;
   logic s2_d;

   // Shift path takes precedence over the mode-driven s1 input and kills the toggle XOR.
   always_comb begin
      s1_d = D;
      if (mode == MODE_TOGGLE) begin
         s1_d = s1_q ^ D;
      end
`ifdef MUX8LUT_OUTREG_SHIFT_EN
      if (shift_sel) begin
         s1_d = shift_d;
      end
`endif
      s2_d = s1_q;
   end

   always_ff @(posedge UserCLK) begin
      if (SR) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else if (EN) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   always_comb begin
      Q = D;
      case (mode)
         MODE_BYPASS: Q = D;
         MODE_REG1:   Q = s1_q;
         MODE_REG2:   Q = s2_q;
         MODE_TOGGLE: Q = s1_q;
         default:     Q = D;
      endcase
   end

   assign s1 = s1_q;

endmodule

`default_nettype wire

// File: rtl/mux8lut_out_reg.sv
// ============================================================================
// mux8lut_out_reg : four-lane output register stage behind the MUX8LUT block.
// Optional macro: MUX8LUT_OUTREG_SHIFT_EN (4-bit shift chain). Rev 1.0
// ============================================================================
`default_nettype none

module mux8lut_out_reg
   import mux8lut_outreg_pkg::*;
#(
`ifdef MUX8LUT_OUTREG_SHIFT_EN
   parameter int NoConfigBits = 9
`else
   parameter int NoConfigBits = 8
`endif
)(
   input  logic                    UserCLK,
   input  logic                    SR,
   input  logic                    EN,
   input  logic                    M_AB,
   input  logic                    M_AD,
   input  logic                    M_AH,
   input  logic                    M_EF,
   input  logic                    SHIFT_IN,
   output logic                    Q_AB,
   output logic                    Q_AD,
   output logic                    Q_AH,
   output logic                    Q_EF,
   output logic                    SHIFT_OUT,
   input  logic [NoConfigBits-1:0] ConfigBits
);

   logic [NUM_LANES-1:0] w_d;
   logic [NUM_LANES-1:0] w_q;
   logic [NUM_LANES-1:0] w_s1;

   assign w_d = {M_EF, M_AH, M_AD, M_AB};
   assign {Q_EF, Q_AH, Q_AD, Q_AB} = w_q;

`ifdef MUX8LUT_OUTREG_SHIFT_EN
   logic [NUM_LANES-1:0] w_shift_d;
   logic                 w_shift_sel;

   // Lane 0 is fed from SHIFT_IN; every other lane from its lower neighbour's s1.
   assign w_shift_d   = {w_s1[NUM_LANES-2:0], SHIFT_IN};
   assign w_shift_sel = ConfigBits[CFG_SHIFT_BIT];
   assign SHIFT_OUT   = w_s1[NUM_LANES-1];
`else
   logic unused_shift_path;
   assign unused_shift_path = ^{w_s1, SHIFT_IN};
   assign SHIFT_OUT         = 1'b0;
`endif

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      mux8lut_outreg_lane u_lane (
         .UserCLK   (UserCLK),
         .SR        (SR),
         .EN        (EN),
         .D         (w_d[n]),
         .mode      (ConfigBits[cfg_mode_lsb(n) +: CFG_MODE_W]),
`ifdef MUX8LUT_OUTREG_SHIFT_EN
         .shift_sel (w_shift_sel),
         .shift_d   (w_shift_d[n]),
`endif
         .Q         (w_q[n]),
         .s1        (w_s1[n])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_mux8lut_out_reg.sv
// ============================================================================
// tb_mux8lut_out_reg : directed scoreboard bench for mux8lut_out_reg.
// Honours MUX8LUT_OUTREG_SHIFT_EN when defined.               Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux8lut_out_reg;

`ifdef MUX8LUT_OUTREG_SHIFT_EN
   localparam int NCB = 9;
`else
   localparam int NCB = 8;
`endif

   logic           UserCLK = 1'b0;
   logic           SR = 1'b0;
   logic           EN = 1'b0;
   logic           M_AB = 1'b0;
   logic           M_AD = 1'b0;
   logic           M_AH = 1'b0;
   logic           M_EF = 1'b0;
   logic           SHIFT_IN = 1'b0;
   logic           Q_AB;
   logic           Q_AD;
   logic           Q_AH;
   logic           Q_EF;
   logic           SHIFT_OUT;
   logic [NCB-1:0] ConfigBits = '0;

   // Observed/expected vectors are {SHIFT_OUT, Q_EF, Q_AH, Q_AD, Q_AB}.
   typedef struct {
      string      tag;
      logic [4:0] exp;
      logic [4:0] mask;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mux8lut_out_reg dut (
      .UserCLK    (UserCLK),
      .SR         (SR),
      .EN         (EN),
      .M_AB       (M_AB),
      .M_AD       (M_AD),
      .M_AH       (M_AH),
      .M_EF       (M_EF),
      .SHIFT_IN   (SHIFT_IN),
      .Q_AB       (Q_AB),
      .Q_AD       (Q_AD),
      .Q_AH       (Q_AH),
      .Q_EF       (Q_EF),
      .SHIFT_OUT  (SHIFT_OUT),
      .ConfigBits (ConfigBits)
   );

   always #5 UserCLK = ~UserCLK;

   task automatic tick();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic push(input string tag, input logic [4:0] exp, input logic [4:0] mask);
      exp_t e;
      e.tag  = tag;
      e.exp  = exp;
      e.mask = mask;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [4:0] obs;
      obs = {SHIFT_OUT, Q_EF, Q_AH, Q_AD, Q_AB};
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %b required a queued expectation", obs);
      end else begin
         e = sb.pop_front();
         assert ((obs & e.mask) === (e.exp & e.mask)) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b (mask %b)", e.tag, obs, e.exp, e.mask);
         end
      end
   endtask

   task automatic set_cfg(input logic [7:0] modes, input logic shift);
      ConfigBits = '0;
      ConfigBits[7:0] = modes;
`ifdef MUX8LUT_OUTREG_SHIFT_EN
      ConfigBits[8] = shift;
`else
      if (shift) ConfigBits[7:0] = modes;
`endif
   endtask

   task automatic do_reset();
      SR = 1'b1;
      EN = 1'b1;
      tick();
      SR = 1'b0;
   endtask

   logic [3:0] stream;

   initial begin
      // Reset: all lanes REG1, inputs high.
      set_cfg(8'b01_01_01_01, 1'b0);
      {M_EF, M_AH, M_AD, M_AB} = 4'b1111;
      EN = 1'b1;
      SR = 1'b1;
      push("reset_q_zero", 5'b00000, 5'b11111);
      tick();
      check_out();
      SR = 1'b0;
      push("reset_release", 5'b01111, 5'b01111);
      tick();
      check_out();

      // Latency: lane0 BYPASS, lane1 REG1, lane2 REG2, lane3 REG1.
      set_cfg(8'b01_10_01_00, 1'b0);
      do_reset();
      stream = 4'b1101; // applied LSB first: 1,0,1,1
      for (int k = 0; k < 4; k++) begin
         {M_AH, M_AD, M_AB} = {3{stream[k]}};
         #1;
         push("latency_bypass_same_cycle", {4'b0000, stream[k]}, 5'b00001);
         check_out();
         push("latency_reg1_reg2",
              {2'b00, (k == 0) ? 1'b0 : stream[k-1], stream[k], stream[k]}, 5'b00111);
         tick();
         check_out();
      end
      {M_AH, M_AD, M_AB} = 3'b000;
      push("latency_drain", 5'b00100, 5'b00111);
      tick();
      check_out();

      // Enable: lane3 REG1 with EN low holds at 0.
      set_cfg(8'b01_01_01_01, 1'b0);
      do_reset();
      M_EF = 1'b1;
      EN   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push("enable_hold", 5'b00000, 5'b01000);
         tick();
         check_out();
      end
      EN = 1'b1;
      push("enable_capture", 5'b01000, 5'b01000);
      tick();
      check_out();

      // Toggle: lane1 mode 11.
      set_cfg(8'b01_01_11_01, 1'b0);
      do_reset();
      M_AD = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push("toggle_seq", (k % 2 == 0) ? 5'b00010 : 5'b00000, 5'b00010);
         tick();
         check_out();
      end
      M_AD = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push("toggle_hold", 5'b00010, 5'b00010);
         tick();
         check_out();
      end

      // SR priority over EN with lane2 REG2 full of ones.
      set_cfg(8'b01_10_01_01, 1'b0);
      do_reset();
      M_AH = 1'b1;
      push("reg2_fill_1", 5'b00000, 5'b00100);
      tick();
      check_out();
      push("reg2_fill_2", 5'b00100, 5'b00100);
      tick();
      check_out();
      SR = 1'b1;
      EN = 1'b1;
      push("sr_over_en", 5'b00000, 5'b00100);
      tick();
      check_out();
      SR = 1'b0;
      EN = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push("sr_then_en_low", 5'b00000, 5'b00100);
         tick();
         check_out();
      end
      EN = 1'b1;
      push("reg2_refill_1", 5'b00000, 5'b00100);
      tick();
      check_out();
      push("reg2_refill_2", 5'b00100, 5'b00100);
      tick();
      check_out();

      // BYPASS follows D while SR is held.
      set_cfg(8'b01_01_01_00, 1'b0);
      SR   = 1'b1;
      M_AB = 1'b1;
      #1;
      push("bypass_during_sr_hi", 5'b00001, 5'b00001);
      check_out();
      M_AB = 1'b0;
      #1;
      push("bypass_during_sr_lo", 5'b00000, 5'b00001);
      check_out();
      tick();
      SR = 1'b0;

      // Shift chain (or its absence).
      {M_EF, M_AH, M_AD, M_AB} = 4'b1111;
      EN = 1'b1;
`ifdef MUX8LUT_OUTREG_SHIFT_EN
      set_cfg(8'b01_01_01_01, 1'b1);
      do_reset();
      stream = 4'b1101; // 1,0,1,1 LSB first
      for (int k = 0; k < 4; k++) begin
         SHIFT_IN = stream[k];
         tick();
      end
      push("shift_result", 5'b11011, 5'b11111);
      check_out();
`else
      set_cfg(8'b01_01_01_01, 1'b0);
      do_reset();
      stream = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         SHIFT_IN = stream[k];
         push("no_shift_out_zero", 5'b01111, 5'b11111);
         tick();
         check_out();
      end
`endif

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
